harddrive_seek: RTL and testbench

Parametrised, handshaked successor to the single-cycle track/sector store. It holds `TRACKS × SECTORS` words of `DATA_WIDTH` bits and models a moving head: each request seeks from the current head track to the target track, then performs one read or write access. A request/busy/done handshake lets the processor's I/O path stall on disk operations instead of assuming zero-latency access.

---
 rtl/harddrive_seek_if.sv | 30 +++
 rtl/harddrive_seek.sv | 190 +++++++++++++++++++
 tb/tb_harddrive_seek.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/harddrive_seek_if.sv
// Request/response bundle between a processor I/O path and harddrive_seek.
//   master : drives request, flag_write_hd, track, sector, data_write;
//            observes busy, done, error, output_hard_drive, head_track.
//   slave  : the disk model, with the opposite directions.
interface harddrive_seek_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int TRACK_BITS  = 7,
    parameter int SECTOR_BITS = 14
) ();
    logic                   request;
    logic                   flag_write_hd;
    logic [TRACK_BITS-1:0]  track;
    logic [SECTOR_BITS-1:0] sector;
    logic [DATA_WIDTH-1:0]  data_write;
    logic                   busy;
    logic                   done;
    logic                   error;
    logic [DATA_WIDTH-1:0]  output_hard_drive;
    logic [TRACK_BITS-1:0]  head_track;

    modport master (
        output request, flag_write_hd, track, sector, data_write,
        input  busy, done, error, output_hard_drive, head_track
    );

    modport slave (
        input  request, flag_write_hd, track, sector, data_write,
        output busy, done, error, output_hard_drive, head_track
    );
endinterface

// File: rtl/harddrive_seek.sv
// Track/sector word store with a moving-head seek model and a
// request/busy/done handshake.
//   clock : rising-edge clock
//   reset : synchronous, active-high; returns FSM, head and outputs to zero
//           (storage contents are kept)
//   hd    : harddrive_seek_if slave port (request, flag_write_hd, track,
//           sector, data_write in; busy, done, error, output_hard_drive,
//           head_track out)
// A request seeks |target - head| * SEEK_CYCLES cycles, then spends one
// cycle in ACCESS and one cycle in DONE. Out-of-range addresses skip
// straight to DONE with error set.
module harddrive_seek #(
    parameter int DATA_WIDTH  = 32,
    parameter int TRACK_BITS  = 7,
    parameter int SECTOR_BITS = 14,
    parameter int TRACKS      = 4,
    parameter int SECTORS     = 4,
    parameter int SEEK_CYCLES = 2
) (
    input  logic             clock,
    input  logic             reset,
    harddrive_seek_if.slave  hd
);

    localparam int WORDS   = TRACKS * SECTORS;
    localparam int ADDR_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CNT_MAX = (TRACKS - 1) * SEEK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam int PH_W    = (SEEK_CYCLES > 1) ? $clog2(SEEK_CYCLES) : 1;

    localparam logic [PH_W-1:0]        PH_INIT   = PH_W'((SEEK_CYCLES > 0) ? SEEK_CYCLES - 1 : 0);
    localparam logic [TRACK_BITS:0]    TRK_LIMIT = (TRACK_BITS + 1)'(TRACKS);
    localparam logic [SECTOR_BITS:0]   SEC_LIMIT = (SECTOR_BITS + 1)'(SECTORS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEEK   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Unsigned track distance as max - min, so no signed wrap is involved.
    function automatic logic [TRACK_BITS-1:0] track_distance(
        input logic [TRACK_BITS-1:0] a,
        input logic [TRACK_BITS-1:0] b
    );
        if (a >= b) begin
            track_distance = a - b;
        end else begin
            track_distance = b - a;
        end
    endfunction

    state_t                 state_r;
    logic                   wr_r;
    logic [TRACK_BITS-1:0]  trk_r;
    logic [SECTOR_BITS-1:0] sec_r;
    logic [DATA_WIDTH-1:0]  wdata_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [PH_W-1:0]        phase_r;
    logic [TRACK_BITS-1:0]  head_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   error_r;
    logic [DATA_WIDTH-1:0]  rdata_r;

    // Storage starts at zero and is deliberately outside the reset domain.
    logic [DATA_WIDTH-1:0]  mem_r [0:WORDS-1] = '{default: '0};

    logic                   range_err_s;
    logic [TRACK_BITS-1:0]  dist_s;
    logic [CNT_W-1:0]       load_s;
    logic [ADDR_W-1:0]      idx_s;

    // Decode of the incoming request and of the latched address.
    always_comb begin
        range_err_s = 1'b0;
        dist_s      = '0;
        load_s      = '0;
        idx_s       = '0;
        range_err_s = ({1'b0, hd.track} >= TRK_LIMIT) || ({1'b0, hd.sector} >= SEC_LIMIT);
        dist_s      = track_distance(hd.track, head_r);
        // Only consumed for in-range targets, where dist <= TRACKS-1 fits CNT_W.
        load_s      = CNT_W'(32'(dist_s) * SEEK_CYCLES);
        idx_s       = ADDR_W'(32'(trk_r) * SECTORS + 32'(sec_r));
    end

    // Control FSM with all handshake outputs, head position and read data registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
            wr_r    <= 1'b0;
            trk_r   <= '0;
            sec_r   <= '0;
            wdata_r <= '0;
            cnt_r   <= '0;
            phase_r <= '0;
            head_r  <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            error_r <= 1'b0;
            rdata_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r  <= 1'b0;
                    error_r <= 1'b0;
                    if (hd.request) begin
                        wr_r    <= hd.flag_write_hd;
                        trk_r   <= hd.track;
                        sec_r   <= hd.sector;
                        wdata_r <= hd.data_write;
                        busy_r  <= 1'b1;
                        if (range_err_s) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                            error_r <= 1'b1;
                        end else if (load_s == '0) begin
                            state_r <= ST_ACCESS;
                        end else begin
                            state_r <= ST_SEEK;
                            cnt_r   <= load_s;
                            phase_r <= PH_INIT;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_SEEK: begin
                    cnt_r <= cnt_r - CNT_W'(1);
                    // The head moves on the last cycle of each SEEK_CYCLES
                    // window, so it lands on the target as the count hits 0.
                    if (phase_r == '0) begin
                        phase_r <= PH_INIT;
                        if (trk_r > head_r) begin
                            head_r <= head_r + TRACK_BITS'(1);
                        end else if (trk_r < head_r) begin
                            head_r <= head_r - TRACK_BITS'(1);
                        end else begin
                            head_r <= head_r;
                        end
                    end else begin
                        phase_r <= phase_r - PH_W'(1);
                    end
                    if (cnt_r == CNT_W'(1)) begin
                        state_r <= ST_ACCESS;
                    end else begin
                        state_r <= ST_SEEK;
                    end
                end
                ST_ACCESS: begin
                    if (!wr_r) begin
                        rdata_r <= mem_r[idx_s];
                    end else begin
                        rdata_r <= rdata_r;
                    end
                    state_r <= ST_DONE;
                    done_r  <= 1'b1;
                    error_r <= 1'b0;
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    error_r <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    error_r <= 1'b0;
                end
            endcase
        end
    end

    // Storage write port; reset on the ACCESS edge cancels the write.
    always_ff @(posedge clock) begin
        if (!reset && (state_r == ST_ACCESS) && wr_r) begin
            mem_r[idx_s] <= wdata_r;
        end
    end

    assign hd.busy              = busy_r;
    assign hd.done              = done_r;
    assign hd.error             = error_r;
    assign hd.output_hard_drive = rdata_r;
    assign hd.head_track        = head_r;

endmodule

// File: tb/tb_harddrive_seek.sv
// Directed self-checking bench for harddrive_seek (default parameters:
// 4 tracks x 4 sectors, SEEK_CYCLES = 2). Cycle numbering: cycle 1 is the
// cycle right after the edge that samples request.
module tb_harddrive_seek;

    logic clock;
    logic reset;

    harddrive_seek_if #(.DATA_WIDTH(32), .TRACK_BITS(7), .SECTOR_BITS(14)) hd ();

    harddrive_seek #(
        .DATA_WIDTH(32), .TRACK_BITS(7), .SECTOR_BITS(14),
        .TRACKS(4), .SECTORS(4), .SEEK_CYCLES(2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .hd    (hd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_total = 0;
    int n_pass  = 0;

    // Per-cycle observations of the most recent operation.
    logic [6:0]  head_hist [0:31];
    int          done_cyc;
    logic        err_at_done;
    logic        busy_at_done;
    logic [6:0]  head_at_done;
    logic [31:0] out_at_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issue one request and follow it to its done pulse (bounded), then
    // advance into the following IDLE cycle.
    task automatic run_op(input logic wr, input logic [6:0] trk,
                          input logic [13:0] sec, input logic [31:0] data);
        int cyc;
        for (int i = 0; i < 32; i++) head_hist[i] = 7'h7f;
        hd.request       = 1'b1;
        hd.flag_write_hd = wr;
        hd.track         = trk;
        hd.sector        = sec;
        hd.data_write    = data;
        step();
        hd.request = 1'b0;
        cyc = 1;
        head_hist[cyc] = hd.head_track;
        while (hd.done !== 1'b1 && cyc < 30) begin
            step();
            cyc++;
            head_hist[cyc] = hd.head_track;
        end
        done_cyc     = cyc;
        err_at_done  = hd.error;
        busy_at_done = hd.busy;
        head_at_done = hd.head_track;
        out_at_done  = hd.output_hard_drive;
        step();
    endtask

    initial begin
        reset            = 1'b1;
        hd.request       = 1'b0;
        hd.flag_write_hd = 1'b0;
        hd.track         = 7'd0;
        hd.sector        = 14'd0;
        hd.data_write    = 32'd0;
        step();
        step();

        // Reset state.
        check("rst_busy", {31'd0, hd.busy}, 32'd0);
        check("rst_done", {31'd0, hd.done}, 32'd0);
        check("rst_error", {31'd0, hd.error}, 32'd0);
        check("rst_out", hd.output_hard_drive, 32'd0);
        check("rst_head", {25'd0, hd.head_track}, 32'd0);
        reset = 1'b0;

        // Write 0xDEADBEEF to 3/1 from head 0: D = 6, done in cycle 8.
        run_op(1'b1, 7'd3, 14'd1, 32'hDEADBEEF);
        check("w31_done_cyc", done_cyc, 32'd8);
        check("w31_error", {31'd0, err_at_done}, 32'd0);
        check("w31_busy_at_done", {31'd0, busy_at_done}, 32'd1);
        check("w31_head", {25'd0, head_at_done}, 32'd3);
        check("w31_head_c2", {25'd0, head_hist[2]}, 32'd0);
        check("w31_head_c3", {25'd0, head_hist[3]}, 32'd1);
        check("w31_head_c5", {25'd0, head_hist[5]}, 32'd2);
        check("w31_out_kept", out_at_done, 32'd0);
        check("w31_busy_after", {31'd0, hd.busy}, 32'd0);

        // Read back 3/1 with the head already there: D = 0, done in cycle 2.
        run_op(1'b0, 7'd3, 14'd1, 32'd0);
        check("r31_done_cyc", done_cyc, 32'd2);
        check("r31_data", out_at_done, 32'hDEADBEEF);
        check("r31_error", {31'd0, err_at_done}, 32'd0);

        // Read 0/1 from head 3: head 3,3,2,2,1,1,0, done in cycle 8, data 0.
        run_op(1'b0, 7'd0, 14'd1, 32'd0);
        check("r01_done_cyc", done_cyc, 32'd8);
        check("r01_head_c2", {25'd0, head_hist[2]}, 32'd3);
        check("r01_head_c3", {25'd0, head_hist[3]}, 32'd2);
        check("r01_head_c5", {25'd0, head_hist[5]}, 32'd1);
        check("r01_head_c7", {25'd0, head_hist[7]}, 32'd0);
        check("r01_data", out_at_done, 32'd0);

        // Reload read data and move head to 3 so error cases show they keep it.
        run_op(1'b0, 7'd3, 14'd1, 32'd0);
        check("r31b_data", out_at_done, 32'hDEADBEEF);

        // Out-of-range track (write attempt): done/error in cycle 1.
        run_op(1'b1, 7'd4, 14'd0, 32'h55555555);
        check("etrk_done_cyc", done_cyc, 32'd1);
        check("etrk_error", {31'd0, err_at_done}, 32'd1);
        check("etrk_head", {25'd0, head_at_done}, 32'd3);
        check("etrk_out", out_at_done, 32'hDEADBEEF);

        // Out-of-range sector (write attempt).
        run_op(1'b1, 7'd0, 14'd5, 32'h55555555);
        check("esec_done_cyc", done_cyc, 32'd1);
        check("esec_error", {31'd0, err_at_done}, 32'd1);
        check("esec_head", {25'd0, head_at_done}, 32'd3);
        check("esec_out", out_at_done, 32'hDEADBEEF);
        check("esec_error_after", {31'd0, hd.error}, 32'd0);

        // Read 0/0 from head 3, with a write request to 2/2 pulsed in cycle 3.
        hd.request       = 1'b1;
        hd.flag_write_hd = 1'b0;
        hd.track         = 7'd0;
        hd.sector        = 14'd0;
        step();
        hd.request = 1'b0;
        step();
        hd.request       = 1'b1;
        hd.flag_write_hd = 1'b1;
        hd.track         = 7'd2;
        hd.sector        = 14'd2;
        hd.data_write    = 32'h12345678;
        step();
        hd.request = 1'b0;
        done_cyc = 3;
        while (hd.done !== 1'b1 && done_cyc < 30) begin
            step();
            done_cyc++;
        end
        check("busy_req_done_cyc", done_cyc, 32'd8);
        check("r00_data", hd.output_hard_drive, 32'd0);
        check("r00_head", {25'd0, hd.head_track}, 32'd0);
        step();
        check("busy_req_not_queued", {31'd0, hd.busy}, 32'd0);

        // Ignored write and the erroring writes must not have touched memory.
        run_op(1'b0, 7'd2, 14'd2, 32'd0);
        check("r22_done_cyc", done_cyc, 32'd6);
        check("r22_data", out_at_done, 32'd0);
        run_op(1'b0, 7'd1, 14'd1, 32'd0);
        check("r11_data", out_at_done, 32'd0);
        run_op(1'b0, 7'd3, 14'd1, 32'd0);
        check("r31c_data", out_at_done, 32'hDEADBEEF);

        // Write 0xCAFEF00D to 3/0 from head 1 (D = 4), reset in cycle 2.
        run_op(1'b0, 7'd1, 14'd0, 32'd0);
        hd.request       = 1'b1;
        hd.flag_write_hd = 1'b1;
        hd.track         = 7'd3;
        hd.sector        = 14'd0;
        hd.data_write    = 32'hCAFEF00D;
        step();
        hd.request = 1'b0;
        step();
        check("seek_busy_mid", {31'd0, hd.busy}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_busy", {31'd0, hd.busy}, 32'd0);
        check("mid_rst_head", {25'd0, hd.head_track}, 32'd0);
        check("mid_rst_done", {31'd0, hd.done}, 32'd0);
        check("mid_rst_out", hd.output_hard_drive, 32'd0);

        run_op(1'b0, 7'd3, 14'd0, 32'd0);
        check("r30_done_cyc", done_cyc, 32'd8);
        check("r30_data", out_at_done, 32'd0);
        run_op(1'b0, 7'd3, 14'd1, 32'd0);
        check("r31_after_rst", out_at_done, 32'hDEADBEEF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
